// File: rtl/sba_pkg.sv
// Shared types and widths for the SBA interconnect and its address decoder.
package sba_pkg;

  typedef enum logic [1:0] {
    SBA_IDLE = 2'd0,
    SBA_BUSY = 2'd1,
    SBA_RESP = 2'd2
  } sba_state_t;

  localparam int SBA_AW  = 32;
  localparam int SBA_DW  = 32;
  localparam int SBA_WEW = 4;

  // One-hot expansion of a slave index (up to 16 slaves)
  function automatic logic [15:0] sba_onehot(input logic [3:0] idx);
    logic [15:0] r;
    r      = 16'h0000;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sba_addr_decode.sv
// Combinational priority decoder: address select field -> {hit, slave index}.
module sba_addr_decode #(
  parameter int                  N_SLAVES  = 4,
  parameter int                  FIELD_W   = 4,
  parameter logic [8*N_SLAVES-1:0] SLAVE_SEL = {8'h03, 8'h02, 8'h01, 8'h00}
) (
  input  logic [FIELD_W-1:0] field,
  output logic               hit,
  output logic [3:0]         idx
);

  logic [7:0] field8;

  // Scan from the top so the lowest matching slot is the one left standing
  always_comb begin
    field8               = 8'h00;
    field8[FIELD_W-1:0]  = field;
    hit                  = 1'b0;
    idx                  = 4'h0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (SLAVE_SEL[8*i +: 8] == field8) begin
        hit = 1'b1;
        idx = 4'(i);
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/sba_interconnect.sv
// SBA interconnect: one master to N_SLAVES slaves, decoded on an address field.
// Optional hung-slave watchdog enabled by defining SBA_TIMEOUT_EN.
module sba_interconnect
  import sba_pkg::*;
#(
  parameter int                    N_SLAVES       = 4,
  parameter int                    SEL_MSB        = 31,
  parameter int                    SEL_LSB        = 28,
  parameter logic [8*N_SLAVES-1:0] SLAVE_SEL      = {8'h03, 8'h02, 8'h01, 8'h00},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [SBA_AW-1:0]          i_m_addr,
  input  logic                       i_m_stb,
  input  logic [SBA_WEW-1:0]         i_m_we,
  input  logic [SBA_DW-1:0]          i_m_dat_w,
  output logic [SBA_DW-1:0]          o_m_dat_r,
  output logic                       o_m_ack,
  output logic                       o_m_err,
  output logic [N_SLAVES-1:0]        o_s_stb,
  output logic [SBA_AW-1:0]          o_s_addr,
  output logic [SBA_WEW-1:0]         o_s_we,
  output logic [SBA_DW-1:0]          o_s_dat_w,
  input  logic [N_SLAVES-1:0]        i_s_ack,
  input  logic [SBA_DW*N_SLAVES-1:0] i_s_dat_r
);

  localparam int FIELD_W = SEL_MSB - SEL_LSB + 1;

  sba_state_t        state, state_next;
  logic [3:0]        sel_q;
  logic              err_q;
  logic [SBA_DW-1:0] dat_q;
  logic              dec_hit;
  logic [3:0]        dec_idx;
  logic              sel_ack;
  logic [SBA_DW-1:0] sel_dat;
  logic              tmo_hit;
  logic [15:0]       stb_onehot;

  sba_addr_decode #(
    .N_SLAVES  (N_SLAVES),
    .FIELD_W   (FIELD_W),
    .SLAVE_SEL (SLAVE_SEL)
  ) u_decode (
    .field (i_m_addr[SEL_MSB:SEL_LSB]),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  // Only the selected slave's ack and data are visible to the FSM
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = {SBA_DW{1'b0}};
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == 4'(i)) begin
        sel_ack = i_s_ack[i];
        sel_dat = i_s_dat_r[SBA_DW*i +: SBA_DW];
      end else begin
        sel_ack = sel_ack;
      end
    end
  end

`ifdef SBA_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counts BUSY cycles; abort fires on the cycle that would reach the limit
  always_ff @(posedge i_clk) begin
    if (i_rst || state != SBA_BUSY) begin
      tmo_cnt <= 16'h0000;
    end else if (!sel_ack) begin
      tmo_cnt <= tmo_cnt + 16'h0001;
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  assign tmo_hit = (state == SBA_BUSY) && !sel_ack && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SBA_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      SBA_IDLE: begin
        if (i_m_stb) state_next = dec_hit ? SBA_BUSY : SBA_RESP;
        else         state_next = SBA_IDLE;
      end
      SBA_BUSY: begin
        if (sel_ack || tmo_hit) state_next = SBA_RESP;
        else                    state_next = SBA_BUSY;
      end
      SBA_RESP: state_next = SBA_IDLE;
      default:  state_next = SBA_IDLE;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_s_addr  <= {SBA_AW{1'b0}};
      o_s_we    <= {SBA_WEW{1'b0}};
      o_s_dat_w <= {SBA_DW{1'b0}};
      sel_q     <= 4'h0;
      err_q     <= 1'b0;
      dat_q     <= {SBA_DW{1'b0}};
    end else begin
      case (state)
        SBA_IDLE: begin
          if (i_m_stb) begin
            o_s_addr  <= i_m_addr;
            o_s_we    <= i_m_we;
            o_s_dat_w <= i_m_dat_w;
            sel_q     <= dec_idx;
            err_q     <= ~dec_hit;
            dat_q     <= {SBA_DW{1'b0}};
          end else begin
            err_q     <= err_q;
          end
        end
        SBA_BUSY: begin
          if (sel_ack) begin
            dat_q <= sel_dat;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            dat_q <= {SBA_DW{1'b0}};
            err_q <= 1'b1;
          end else begin
            dat_q <= dat_q;
          end
        end
        default: dat_q <= dat_q;
      endcase
    end
  end

  assign stb_onehot = sba_onehot(sel_q);

  // Outputs are pure decodes of registered state
  always_comb begin
    o_s_stb   = {N_SLAVES{1'b0}};
    o_m_ack   = 1'b0;
    o_m_err   = 1'b0;
    o_m_dat_r = {SBA_DW{1'b0}};
    case (state)
      SBA_BUSY: o_s_stb = stb_onehot[N_SLAVES-1:0];
      SBA_RESP: begin
        o_m_ack   = 1'b1;
        o_m_err   = err_q;
        o_m_dat_r = err_q ? {SBA_DW{1'b0}} : dat_q;
      end
      default: o_m_ack = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sba_interconnect.sv
// Self-checking bench for sba_interconnect: vector table, directed corner sequences
// and randomized transactions against an address-map reference model.
module tb_sba_interconnect;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  m_addr;
  logic         m_stb;
  logic [3:0]   m_we;
  logic [31:0]  m_dat_w;
  logic [31:0]  m_dat_r;
  logic         m_ack;
  logic         m_err;
  logic [3:0]   s_stb;
  logic [31:0]  s_addr;
  logic [3:0]   s_we;
  logic [31:0]  s_dat_w;
  logic [3:0]   s_ack;
  logic [127:0] s_dat_r;

  logic [31:0]  mem [4];
  logic [3:0]   hang;
  logic [31:0]  seen_addr [4];
  logic [3:0]   seen_we [4];
  logic [31:0]  seen_dat [4];
  logic [7:0]   sel_tab [4];

  int checks = 0;
  int failures = 0;

  sba_interconnect #(
    .N_SLAVES       (4),
    .SEL_MSB        (31),
    .SEL_LSB        (28),
    .SLAVE_SEL      ({8'h03, 8'h02, 8'h01, 8'h00}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_m_addr  (m_addr),
    .i_m_stb   (m_stb),
    .i_m_we    (m_we),
    .i_m_dat_w (m_dat_w),
    .o_m_dat_r (m_dat_r),
    .o_m_ack   (m_ack),
    .o_m_err   (m_err),
    .o_s_stb   (s_stb),
    .o_s_addr  (s_addr),
    .o_s_we    (s_we),
    .o_s_dat_w (s_dat_w),
    .i_s_ack   (s_ack),
    .i_s_dat_r (s_dat_r)
  );

  always #5 clk = ~clk;

  assign s_dat_r = {mem[3], mem[2], mem[1], mem[0]};

  // Registered-ack slaves: ack every cycle the strobe is seen (unless hung)
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      s_ack[i] <= s_stb[i] & ~hang[i];
      if (s_stb[i]) begin
        seen_addr[i] <= s_addr;
        seen_we[i]   <= s_we;
        seen_dat[i]  <= s_dat_w;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address map: lowest matching slot wins, -1 when unmapped
  function automatic int ref_slot(input logic [31:0] a);
    logic [7:0] f;
    f = {4'h0, a[31:28]};
    for (int i = 0; i < 4; i++)
      if (sel_tab[i] == f) return i;
    return -1;
  endfunction

  // One master transaction; drop = cycle at which stb is lowered (0 = keep high)
  task automatic xfer(input string nm, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] d, input int drop, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_dat,
                      input logic [3:0] exp_stb, input int exp_stb_cycles);
    int lat = 0;
    int stb_cycles = 0;
    bit got = 0;
    bit stb_bad = 0;
    m_addr = a; m_we = we; m_dat_w = d; m_stb = 1'b1;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (lat == drop) m_stb = 1'b0;
      if (m_ack) got = 1;
      if (s_stb == exp_stb && exp_stb != 4'b0000) stb_cycles++;
      else if (s_stb != 4'b0000) stb_bad = 1;
    end
    check({nm, "_ack_seen"}, 32'(got), 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_err"}, 32'(m_err), 32'(exp_err));
    check({nm, "_dat"}, m_dat_r, exp_dat);
    check({nm, "_stb_cycles"}, 32'(stb_cycles), 32'(exp_stb_cycles));
    check({nm, "_stb_onehot"}, 32'(stb_bad), 32'd0);
    check({nm, "_s_addr"}, s_addr, a);
    check({nm, "_s_we"}, 32'(s_we), 32'(we));
    check({nm, "_s_dat_w"}, s_dat_w, d);
    if (drop != 0) begin
      tick();
      check({nm, "_ack_single"}, 32'(m_ack), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] dat_w;
    logic [31:0] rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_dat;
    logic [3:0]  exp_stb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    sel_tab = '{8'h00, 8'h01, 8'h02, 8'h03};
    hang = 4'b0000;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0000;
    rst = 1'b1; m_stb = 1'b0; m_addr = 32'h0; m_we = 4'h0; m_dat_w = 32'h0;
    tick(); tick(); tick();
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_m_dat_r", m_dat_r, 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    rst = 1'b0;
    tick();

    vecs[0] = '{32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3, 32'hDEAD_BEEF, 4'b0001};
    vecs[1] = '{32'h1000_0004, 4'b0011, 32'hA5A5_1234, 32'h0BAD_F00D, 1'b0, 3, 32'h0BAD_F00D, 4'b0010};
    vecs[2] = '{32'h5000_0000, 4'b0000, 32'h0000_0000, 32'h1234_5678, 1'b1, 1, 32'h0000_0000, 4'b0000};
    vecs[3] = '{32'h2FFF_FFFC, 4'b1111, 32'h0102_0304, 32'hCAFE_0002, 1'b0, 3, 32'hCAFE_0002, 4'b0100};
    vecs[4] = '{32'h3000_0000, 4'b0000, 32'h0000_0000, 32'h3333_3333, 1'b0, 3, 32'h3333_3333, 4'b1000};
    vecs[5] = '{32'hF000_0000, 4'b1000, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1, 1, 32'h0000_0000, 4'b0000};
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) mem[i] = vecs[v].rd;
      xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].we, vecs[v].dat_w, 1,
           vecs[v].exp_lat, vecs[v].exp_err, vecs[v].exp_dat, vecs[v].exp_stb,
           vecs[v].exp_err ? 0 : 2);
      if (v == 1) begin
        check("wr_slave1_addr", seen_addr[1], 32'h1000_0004);
        check("wr_slave1_we", 32'(seen_we[1]), 32'h3);
        check("wr_slave1_dat", seen_dat[1], 32'hA5A5_1234);
      end
    end

    // Hung slave 2: watchdog abort, or indefinite wait without it
    hang = 4'b0100;
`ifdef SBA_TIMEOUT_EN
    xfer("timeout", 32'h2000_0000, 4'b0000, 32'h0, 1, 9, 1'b1, 32'h0, 4'b0100, 8);
`else
    begin
      int acks = 0;
      m_addr = 32'h2000_0000; m_we = 4'h0; m_stb = 1'b1;
      tick();
      m_stb = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (m_ack) acks++;
        tick();
      end
      check("hang_no_ack", 32'(acks), 32'd0);
      check("hang_stb_held", 32'(s_stb), 32'h4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hang_rst_stb", 32'(s_stb), 32'd0);
      tick();
    end
`endif
    hang = 4'b0000;

    // Reset while BUSY: no ack, late slave ack ignored, next request works
    begin
      int acks = 0;
      mem[0] = 32'h7777_0000;
      m_addr = 32'h0000_0000; m_we = 4'h0; m_stb = 1'b1;
      tick();
      check("rstbusy_stb", 32'(s_stb), 32'h1);
      m_stb = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstbusy_stb_cleared", 32'(s_stb), 32'd0);
      check("rstbusy_late_ack_present", 32'(s_ack[0]), 32'd1);
      for (int c = 0; c < 5; c++) begin
        if (m_ack) acks++;
        tick();
      end
      check("rstbusy_no_ack", 32'(acks), 32'd0);
      xfer("after_rst", 32'h0000_0040, 4'b0000, 32'h0, 1, 3, 1'b0, 32'h7777_0000, 4'b0001, 2);
    end

    // Back-to-back: stb held across the first ack, second request to slave 3
    mem[0] = 32'hAAAA_0000; mem[3] = 32'hBBBB_3333;
    xfer("b2b_first", 32'h0000_0000, 4'b0000, 32'h0, 0, 3, 1'b0, 32'hAAAA_0000, 4'b0001, 2);
    xfer("b2b_second", 32'h3000_0000, 4'b0000, 32'h0, 2, 4, 1'b0, 32'hBBBB_3333, 4'b1000, 2);
    mem[3] = 32'hCCCC_3333;
    xfer("b2b_same_a", 32'h3000_0008, 4'b0000, 32'h0, 0, 3, 1'b0, 32'hCCCC_3333, 4'b1000, 2);
    xfer("b2b_same_b", 32'h3000_000C, 4'b0000, 32'h0, 2, 4, 1'b0, 32'hCCCC_3333, 4'b1000, 2);

    // Randomized transactions against the address-map model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  field;
      int          slot;
      field = 4'($urandom_range(0, 7));
      a = {field, 28'($urandom)};
      for (int i = 0; i < 4; i++) mem[i] = $urandom;
      slot = ref_slot(a);
      if (slot < 0)
        xfer($sformatf("rnd%0d", n), a, 4'($urandom), $urandom, 1, 1, 1'b1, 32'h0, 4'b0000, 0);
      else
        xfer($sformatf("rnd%0d", n), a, 4'($urandom), $urandom, 1, 3, 1'b0, mem[slot],
             4'(1 << slot), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
